// File: rtl/phase_aligned_serializer.sv
// phase_aligned_serializer
//   Fast-domain serializer for a wide word produced in a slow sync clock domain.
//   On each phase_i pulse the word is captured into a shadow register and
//   streamed as MULT beats of NBITS. Beat 0 appears one clock after the pulse.
//   The block checks the spacing of phase pulses, locks after LOCK_COUNT good
//   periods and flags slips while locked.
//
//   Optional feature: define PHASE_SER_ERRCNT_EN to build the saturating slip
//   counter on err_cnt_o; otherwise err_cnt_o reads 8'h00.
//
// Ports
//   clk_i      fast clock, posedge
//   rst_n_i    synchronous active-low reset
//   phase_i    1 on the first fast clock of each sync period
//   dat_i      MULT*NBITS sync-domain word, beat k = dat_i[k*NBITS +: NBITS]
//   dat_o      current output beat
//   first_o    dat_o carries beat 0 (LOCKED only)
//   valid_o    dat_o valid (LOCKED only)
//   locked_o   LOCKED state
//   err_o      one-cycle pulse on a slip while LOCKED
//   err_cnt_o  saturating slip count
module phase_aligned_serializer #(
  parameter int MULT       = 4,
  parameter int NBITS      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  phase_i,
  input  logic [MULT*NBITS-1:0] dat_i,
  output logic [NBITS-1:0]      dat_o,
  output logic                  first_o,
  output logic                  valid_o,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
);

  localparam int BW = $clog2(MULT);
  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [BW-1:0] BEND  = BW'(MULT - 1);
  localparam logic [GW-1:0] GLAST = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  state_t                      state, state_nxt;
  logic [BW-1:0]               bcnt, bcnt_nxt;
  logic [GW-1:0]               good, good_nxt;
  logic [MULT-1:0][NBITS-1:0]  shadow;
  logic [MULT-1:0][NBITS-1:0]  dat_beats;
  logic                        at_end, early, missing, slip_err;

  assign dat_beats = dat_i;
  assign at_end    = (bcnt == BEND);
  assign early     = phase_i && !at_end;
  assign missing   = !phase_i && at_end;
  // A pulse always realigns the beat counter, so bcnt doubles as the index of
  // the beat currently on dat_o.
  assign bcnt_nxt  = (phase_i || at_end) ? '0 : bcnt + 1'b1;

  // State register and datapath
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= HUNT;
      bcnt   <= '0;
      good   <= '0;
      shadow <= '0;
      dat_o  <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      good  <= good_nxt;
      err_o <= slip_err;
      if (phase_i) begin
        shadow <= dat_beats;
        dat_o  <= dat_beats[0];
      end else begin
        dat_o  <= shadow[bcnt_nxt];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    slip_err  = 1'b0;
    case (state)
      HUNT: begin
        // first pulse is never judged: there is no reference yet
        if (phase_i) begin
          state_nxt = ALIGN;
          good_nxt  = '0;
        end
      end
      ALIGN: begin
        if (phase_i && at_end) begin
          if (good == GLAST) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good + 1'b1;
          end
        end else if (early) begin
          good_nxt = '0;
        end else if (missing) begin
          state_nxt = HUNT;
          good_nxt  = '0;
        end
      end
      LOCKED: begin
        if (early || missing) begin
          slip_err  = 1'b1;
          state_nxt = ALIGN;
          good_nxt  = '0;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Outputs decoded from the registered state, so they drop on the same
  // edge that raises err_o.
  always_comb begin
    locked_o = (state == LOCKED);
    valid_o  = (state == LOCKED);
    first_o  = (state == LOCKED) && (bcnt == '0);
  end

`ifdef PHASE_SER_ERRCNT_EN
  logic [7:0] err_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      err_cnt <= '0;
    else if (slip_err && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = 8'h00;
`endif

endmodule
